// File: rtl/ddr_wr_serializer_if.sv
// Write-burst bus between the write-data FIFO / command side and the
// DDR write serializer, including the ODDR-facing rise/fall pairs.
interface ddr_wr_serializer_if #(
  parameter int DQ_W = 16,
  parameter int DM_W = DQ_W / 8
);
  logic                wr_start;
  logic                busy;
  logic [2*DQ_W-1:0]   wd_data;
  logic [2*DM_W-1:0]   wd_mask;
  logic                wd_valid;
  logic                wd_ready;
  logic [DQ_W-1:0]     dq_rise;
  logic [DQ_W-1:0]     dq_fall;
  logic [DM_W-1:0]     dm_rise;
  logic [DM_W-1:0]     dm_fall;
  logic                dq_oe;
  logic                dqs_rise;
  logic                dqs_fall;
  logic                dqs_oe;
  logic                err_underrun;
  logic                err_overlap;
  logic                err_clr;

  modport master (
    output wr_start, wd_data, wd_mask, wd_valid, err_clr,
    input  busy, wd_ready, dq_rise, dq_fall, dm_rise, dm_fall,
           dq_oe, dqs_rise, dqs_fall, dqs_oe, err_underrun, err_overlap
  );

  modport slave (
    input  wr_start, wd_data, wd_mask, wd_valid, err_clr,
    output busy, wd_ready, dq_rise, dq_fall, dm_rise, dm_fall,
           dq_oe, dqs_rise, dqs_fall, dqs_oe, err_underrun, err_overlap
  );
endinterface

// File: rtl/ddr_wr_serializer.sv
// DDR2 write-burst serializer: waits the write latency after wr_start,
// sends the DQS preamble, streams BURST_CYC rise/fall beats pulled from the
// write-data FIFO, then sends the DQS postamble. Every output is a register
// so the ODDR primitives capture rise/fall pairs on the same edge.
// Optional macro DDR_WR_BURST_CNT_EN adds a saturating burst_cnt output.
module ddr_wr_serializer #(
  parameter int DQ_W      = 16,
  parameter int DM_W      = DQ_W / 8,
  parameter int WL        = 3,
  parameter int BURST_CYC = 2
) (
  input  logic                 C,
  input  logic                 R,
  ddr_wr_serializer_if.slave   bus
`ifdef DDR_WR_BURST_CNT_EN
  ,
  output logic [15:0]          burst_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT, PRE, DATA, POST} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WL - 2);
  localparam logic [1:0] BEAT_LAST = 2'(BURST_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [1:0]  beat_cnt, beat_cnt_nxt;
  logic        wd_ready_nxt;

  logic            busy_p0;
  logic            wd_ready_p0;
  logic [DQ_W-1:0] dq_rise_p0, dq_fall_p0;
  logic [DM_W-1:0] dm_rise_p0, dm_fall_p0;
  logic            dq_oe_p0, dqs_rise_p0, dqs_oe_p0;
  logic            err_underrun_p0, err_overlap_p0;
  logic            underrun_evt, overlap_evt;

  // Next-state logic; outputs are registered from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (bus.wr_start) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = PRE;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      PRE: begin
        state_nxt    = DATA;
        beat_cnt_nxt = 2'd0;
      end
      DATA: begin
        if (beat_cnt == BEAT_LAST) begin
          state_nxt    = POST;
          beat_cnt_nxt = 2'd0;
        end else begin
          beat_cnt_nxt = beat_cnt + 2'd1;
        end
      end
      POST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A word is requested one cycle ahead of each DATA beat: during PRE and
    // every DATA beat except the last.
    wd_ready_nxt = (state_nxt == PRE) ||
                   ((state_nxt == DATA) && (beat_cnt_nxt != BEAT_LAST));
  end

  // State and counter registers.
  always_ff @(posedge C) begin
    if (R) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      beat_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Output stage: strobes/enables from the next state, data captured from
  // the FIFO word on every edge where wd_ready was high.
  always_ff @(posedge C) begin
    if (R) begin
      busy_p0     <= 1'b0;
      wd_ready_p0 <= 1'b0;
      dq_oe_p0    <= 1'b0;
      dqs_rise_p0 <= 1'b0;
      dqs_oe_p0   <= 1'b0;
      dq_rise_p0  <= '0;
      dq_fall_p0  <= '0;
      dm_rise_p0  <= '0;
      dm_fall_p0  <= '0;
    end else begin
      busy_p0     <= (state_nxt != IDLE);
      wd_ready_p0 <= wd_ready_nxt;
      dq_oe_p0    <= (state_nxt == DATA);
      dqs_rise_p0 <= (state_nxt == DATA);
      dqs_oe_p0   <= (state_nxt == PRE) || (state_nxt == DATA) || (state_nxt == POST);
      if (wd_ready_p0 && bus.wd_valid) begin
        dq_rise_p0 <= bus.wd_data[DQ_W-1:0];
        dq_fall_p0 <= bus.wd_data[2*DQ_W-1:DQ_W];
        dm_rise_p0 <= bus.wd_mask[DM_W-1:0];
        dm_fall_p0 <= bus.wd_mask[2*DM_W-1:DM_W];
      end else if (wd_ready_p0) begin
        // Starved beat: keep burst timing, mask every byte lane.
        dq_rise_p0 <= '0;
        dq_fall_p0 <= '0;
        dm_rise_p0 <= '1;
        dm_fall_p0 <= '1;
      end else begin
        dq_rise_p0 <= '0;
        dq_fall_p0 <= '0;
        dm_rise_p0 <= '0;
        dm_fall_p0 <= '0;
      end
    end
  end

  assign underrun_evt = wd_ready_p0 && !bus.wd_valid;
  assign overlap_evt  = bus.wr_start && (state != IDLE);

  // Sticky error flags; a new event on the clearing edge wins.
  always_ff @(posedge C) begin
    if (R) begin
      err_underrun_p0 <= 1'b0;
      err_overlap_p0  <= 1'b0;
    end else begin
      err_underrun_p0 <= (err_underrun_p0 && !bus.err_clr) || underrun_evt;
      err_overlap_p0  <= (err_overlap_p0  && !bus.err_clr) || overlap_evt;
    end
  end

`ifdef DDR_WR_BURST_CNT_EN
  // Completed-burst counter, bumped on POST->IDLE and held at all-ones.
  always_ff @(posedge C) begin
    if (R) begin
      burst_cnt <= 16'd0;
    end else if ((state == POST) && (burst_cnt != 16'hFFFF)) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

  assign bus.busy         = busy_p0;
  assign bus.wd_ready     = wd_ready_p0;
  assign bus.dq_rise      = dq_rise_p0;
  assign bus.dq_fall      = dq_fall_p0;
  assign bus.dm_rise      = dm_rise_p0;
  assign bus.dm_fall      = dm_fall_p0;
  assign bus.dq_oe        = dq_oe_p0;
  assign bus.dqs_rise     = dqs_rise_p0;
  assign bus.dqs_fall     = 1'b0;
  assign bus.dqs_oe       = dqs_oe_p0;
  assign bus.err_underrun = err_underrun_p0;
  assign bus.err_overlap  = err_overlap_p0;

endmodule

// File: tb/tb_ddr_wr_serializer.sv
// Bench for ddr_wr_serializer: two instances (WL=3/BL4 and WL=2/BL8) share
// one stimulus stream and are compared every cycle against a model that
// derives each output from the cycle offset relative to the accepted
// wr_start edge. Build with DDR_WR_BURST_CNT_EN to also cover burst_cnt.
module tb_ddr_wr_serializer;

  logic        C = 1'b0;
  logic        R;
  logic        wr_start, wd_valid, err_clr;
  logic [31:0] wd_data;
  logic [3:0]  wd_mask;

  always #5 C = ~C;

  ddr_wr_serializer_if #(.DQ_W(16), .DM_W(2)) if0 ();
  ddr_wr_serializer_if #(.DQ_W(16), .DM_W(2)) if1 ();

  assign if0.wr_start = wr_start;
  assign if0.wd_data  = wd_data;
  assign if0.wd_mask  = wd_mask;
  assign if0.wd_valid = wd_valid;
  assign if0.err_clr  = err_clr;
  assign if1.wr_start = wr_start;
  assign if1.wd_data  = wd_data;
  assign if1.wd_mask  = wd_mask;
  assign if1.wd_valid = wd_valid;
  assign if1.err_clr  = err_clr;

`ifdef DDR_WR_BURST_CNT_EN
  logic [15:0] bcnt0, bcnt1;
`endif

  ddr_wr_serializer #(.DQ_W(16), .DM_W(2), .WL(3), .BURST_CYC(2)) dut0 (
    .C(C), .R(R), .bus(if0.slave)
`ifdef DDR_WR_BURST_CNT_EN
    , .burst_cnt(bcnt0)
`endif
  );

  ddr_wr_serializer #(.DQ_W(16), .DM_W(2), .WL(2), .BURST_CYC(4)) dut1 (
    .C(C), .R(R), .bus(if1.slave)
`ifdef DDR_WR_BURST_CNT_EN
    , .burst_cnt(bcnt1)
`endif
  );

  logic [43:0] obs0, obs1;
  assign obs0 = {if0.busy, if0.wd_ready, if0.dq_rise, if0.dq_fall, if0.dm_rise, if0.dm_fall,
                 if0.dq_oe, if0.dqs_rise, if0.dqs_fall, if0.dqs_oe, if0.err_underrun, if0.err_overlap};
  assign obs1 = {if1.busy, if1.wd_ready, if1.dq_rise, if1.dq_fall, if1.dm_rise, if1.dm_fall,
                 if1.dq_oe, if1.dqs_rise, if1.dqs_fall, if1.dqs_oe, if1.err_underrun, if1.err_overlap};

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int          WLm [2] = '{3, 2};
  int          BCm [2] = '{2, 4};
  int          cyc = 0;
  bit          act [2];
  int          t0  [2];
  bit          eu  [2];
  bit          eo  [2];
  int          bcm [2];
  logic [43:0] exp_vec [2];

  // Phase q = edges since acceptance: PRE at WL-1, DATA at WL..WL+BC-1,
  // POST at WL+BC, idle again at WL+BC+1.
  task automatic model_update();
    int wl, bc, p, q;
    bit su, so, dat, rdy, qs;
    logic [15:0] dr, df;
    logic [1:0]  mr, mf;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      wl = WLm[d]; bc = BCm[d];
      su = 0; so = 0; dat = 0; rdy = 0; qs = 0;
      dr = '0; df = '0; mr = '0; mf = '0;
      if (R) begin
        act[d] = 0; eu[d] = 0; eo[d] = 0; bcm[d] = 0;
        exp_vec[d] = '0;
      end else begin
        if (act[d]) begin
          p = cyc - 1 - t0[d];
          if (wr_start) so = 1;
          if (p >= wl - 1 && p <= wl + bc - 2 && !wd_valid) su = 1;
          if (cyc - t0[d] == wl + bc + 1) begin
            act[d] = 0;
            if (bcm[d] < 65535) bcm[d]++;
          end
        end else if (wr_start) begin
          act[d] = 1; t0[d] = cyc;
        end
        eu[d] = (eu[d] && !err_clr) || su;
        eo[d] = (eo[d] && !err_clr) || so;
        if (act[d]) begin
          q   = cyc - t0[d];
          qs  = (q >= wl - 1) && (q <= wl + bc);
          dat = (q >= wl) && (q <= wl + bc - 1);
          rdy = (q >= wl - 1) && (q <= wl + bc - 2);
          if (dat) begin
            if (wd_valid) begin
              dr = wd_data[15:0]; df = wd_data[31:16];
              mr = wd_mask[1:0];  mf = wd_mask[3:2];
            end else begin
              mr = 2'b11; mf = 2'b11;
            end
          end
        end
        exp_vec[d] = {act[d], rdy, dr, df, mr, mf, dat, dat, 1'b0, qs, eu[d], eo[d]};
      end
    end
  endtask

  task automatic step();
    @(posedge C);
    model_update();
    @(negedge C);
  endtask

  task automatic idle_inputs();
    R = 0; wr_start = 0; wd_valid = 1; err_clr = 0; wd_data = '0; wd_mask = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    R = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if ({obs0, obs1} !== 88'h0) $display("FAIL reset_outputs k=%0d got %h/%h want 0", k, obs0, obs1);
      else n_pass++;
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL reset_model dut%0d got %h want %h", d, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
    end
    R = 0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      wr_start = (k == 0);
      wd_data  = (k == 3) ? 32'hA5A55A5A : (k == 4) ? 32'h0F0FF0F0 : 32'h1234_0000 + 32'(k);
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL basic_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
      if (k == 2) begin
        n_chk++;
        if ({if0.wd_ready, if0.dqs_oe, if0.dq_oe} !== 3'b110)
          $display("FAIL basic_pre got %b want 110", {if0.wd_ready, if0.dqs_oe, if0.dq_oe});
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if ({if0.dq_rise, if0.dq_fall, if0.dqs_rise, if0.dqs_fall, if0.wd_ready} !== {16'h5A5A, 16'hA5A5, 3'b101})
          $display("FAIL basic_beat0 got %h %h want 5a5a a5a5", if0.dq_rise, if0.dq_fall);
        else n_pass++;
      end
      if (k == 4) begin
        n_chk++;
        if ({if0.dq_rise, if0.dq_fall, if0.dq_oe, if0.wd_ready} !== {16'hF0F0, 16'h0F0F, 2'b10})
          $display("FAIL basic_beat1 got %h %h want f0f0 0f0f", if0.dq_rise, if0.dq_fall);
        else n_pass++;
      end
      if (k == 5) begin
        n_chk++;
        if ({if0.dqs_oe, if0.dq_oe, if0.dqs_rise, if0.busy} !== 4'b1001)
          $display("FAIL basic_post got %b want 1001", {if0.dqs_oe, if0.dq_oe, if0.dqs_rise, if0.busy});
        else n_pass++;
      end
      if (k == 6) begin
        n_chk++;
        if ({if0.busy, if0.dqs_oe} !== 2'b00)
          $display("FAIL basic_idle got %b want 00", {if0.busy, if0.dqs_oe});
        else n_pass++;
      end
    end
  endtask

  task automatic test_bl8();
    int n_rdy, n_dat;
    n_rdy = 0; n_dat = 0;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      wr_start = (k == 0);
      wd_data  = (k >= 2 && k <= 5) ? 32'(k - 1) : 32'hDEAD_0000 + 32'(k);
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL bl8_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
      if (if1.wd_ready) n_rdy++;
      if (if1.dq_oe)    n_dat++;
      if (k >= 2 && k <= 5) begin
        n_chk++;
        if ({if1.dq_oe, if1.dqs_rise, if1.dqs_fall, if1.dq_rise, if1.dq_fall} !== {3'b110, 16'(k - 1), 16'h0})
          $display("FAIL bl8_beat k=%0d got %b%b%b %h want 110 %h", k, if1.dq_oe, if1.dqs_rise, if1.dqs_fall, if1.dq_rise, 16'(k - 1));
        else n_pass++;
      end
    end
    n_chk++;
    if (n_dat != 4) $display("FAIL bl8_data_cycles got %0d want 4", n_dat); else n_pass++;
    n_chk++;
    if (n_rdy != 4) $display("FAIL bl8_ready_cycles got %0d want 4", n_rdy); else n_pass++;
  endtask

  task automatic test_underrun();
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      wr_start = (k == 0);
      err_clr  = (k == 0) || (k == 11);
      wd_valid = (k != 4);
      wd_data  = 32'hC3C3_3C3C ^ 32'(k);
      wd_mask  = 4'b0101;
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL underrun_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if ({if0.err_underrun, if0.dm_rise, if0.dm_fall} !== 5'b00101)
          $display("FAIL underrun_first_beat got %b want 00101", {if0.err_underrun, if0.dm_rise, if0.dm_fall});
        else n_pass++;
      end
      if (k == 4) begin
        n_chk++;
        if ({if0.dq_rise, if0.dq_fall, if0.dm_rise, if0.dm_fall, if0.err_underrun} !== {32'h0, 5'b11111})
          $display("FAIL underrun_beat got %h %h %b %b %b want 0 0 11 11 1", if0.dq_rise, if0.dq_fall, if0.dm_rise, if0.dm_fall, if0.err_underrun);
        else n_pass++;
      end
      if (k == 10) begin
        n_chk++;
        if (if0.err_underrun !== 1'b1) $display("FAIL underrun_sticky got %b want 1", if0.err_underrun);
        else n_pass++;
      end
      if (k == 11) begin
        n_chk++;
        if (if0.err_underrun !== 1'b0) $display("FAIL underrun_clear got %b want 0", if0.err_underrun);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overlap();
    int n_busy;
    n_busy = 0;
    for (int k = 0; k < 15; k++) begin
      idle_inputs();
      wr_start = (k == 0) || (k == 1) || (k == 5);
      err_clr  = (k == 1) || (k == 3);
      wd_data  = 32'h7700_0000 + 32'(k);
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL overlap_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
      if (k >= 6 && if0.busy) n_busy++;
      if (k == 1) begin
        n_chk++;
        if (if0.err_overlap !== 1'b1) $display("FAIL overlap_set_wins got %b want 1", if0.err_overlap);
        else n_pass++;
      end
      if (k == 3) begin
        n_chk++;
        if ({if0.err_overlap, if0.dq_oe, if0.dq_rise} !== {2'b01, 16'h0003})
          $display("FAIL overlap_clear_timing got %b %b %h want 0 1 0003", if0.err_overlap, if0.dq_oe, if0.dq_rise);
        else n_pass++;
      end
      if (k == 5) begin
        n_chk++;
        if ({if0.err_overlap, if0.dqs_oe, if0.busy} !== 3'b111)
          $display("FAIL overlap_post got %b want 111", {if0.err_overlap, if0.dqs_oe, if0.busy});
        else n_pass++;
      end
    end
    n_chk++;
    if (n_busy != 0) $display("FAIL overlap_no_second_burst got %0d busy cycles want 0", n_busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      wr_start = (k == 0) || (k == 6);
      R        = (k == 4);
      wd_data  = 32'h5500_AA00 + 32'(k);
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL midreset_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
      if (k == 4) begin
        n_chk++;
        if ({obs0, obs1} !== 88'h0) $display("FAIL midreset_off got %h/%h want 0", obs0, obs1);
        else n_pass++;
      end
      if (k == 9) begin
        n_chk++;
        if ({if0.dq_oe, if0.dqs_rise, if0.dq_rise} !== {2'b11, 16'hAA09})
          $display("FAIL midreset_new_burst got %b%b %h want 11 aa09", if0.dq_oe, if0.dqs_rise, if0.dq_rise);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 420; k++) begin
      idle_inputs();
      if (k < 400) begin
        wr_start = ($urandom_range(0, 5) == 0);
        wd_valid = ($urandom_range(0, 7) != 0);
        err_clr  = ($urandom_range(0, 15) == 0);
        wd_data  = $urandom;
        wd_mask  = 4'($urandom);
      end
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? obs0 : obs1) !== exp_vec[d])
          $display("FAIL random_model dut%0d k=%0d got %h want %h", d, k, (d == 0) ? obs0 : obs1, exp_vec[d]);
        else n_pass++;
      end
    end
  endtask

`ifdef DDR_WR_BURST_CNT_EN
  task automatic test_burst_cnt();
    for (int k = 0; k < 33; k++) begin
      idle_inputs();
      R        = (k == 0) || (k == 32);
      wr_start = (k == 1) || (k == 11) || (k == 21);
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (((d == 0) ? bcnt0 : bcnt1) !== 16'(bcm[d]))
          $display("FAIL burst_cnt_model dut%0d k=%0d got %0d want %0d", d, k, (d == 0) ? bcnt0 : bcnt1, bcm[d]);
        else n_pass++;
      end
      if (k == 31) begin
        n_chk++;
        if ({bcnt0, bcnt1} !== {16'd3, 16'd3}) $display("FAIL burst_cnt_three got %0d/%0d want 3", bcnt0, bcnt1);
        else n_pass++;
      end
      if (k == 32) begin
        n_chk++;
        if ({bcnt0, bcnt1} !== 32'h0) $display("FAIL burst_cnt_reset got %0d/%0d want 0", bcnt0, bcnt1);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    idle_inputs();
    R = 1;
    test_reset();
    test_basic();
    test_bl8();
    test_underrun();
    test_overlap();
    test_mid_reset();
    test_random();
`ifdef DDR_WR_BURST_CNT_EN
    test_burst_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_wr_serializer.md
Name: ddr_wr_serializer

Overview:
- Transmit-side companion to the controller's DDR input capture path.
- On a write command it sequences one DDR2 write burst toward the output DDR registers:
  - waits the write latency,
  - drives the DQS preamble,
  - streams the rise/fall data and mask beats,
  - drives the DQS postamble.
- Sits between the write-data FIFO (valid/ready) and the per-pin ODDR primitives.
- All outputs are registered and are presented as rise/fall pairs for same-edge ODDR capture.

Parameters:
- DQ_W, 16, DQ bus width in bits; must be a multiple of 8.
- DM_W, DQ_W/8, data-mask width, one bit per byte lane.
- WL, 3, write latency in clocks from wr_start acceptance to the first DATA cycle; legal range 2..15.
- BURST_CYC, 2, clocks per burst: 2 means BL4, 4 means BL8; no other values are legal.

Ports:
- C  in  1  controller clock; all logic updates on posedge.
- R  in  1  synchronous, active-high reset.
- wr_start  in  1  one-cycle write-burst request.
- busy  out  1  high whenever the FSM is not in IDLE.
- wd_data  in  2*DQ_W  burst word; [DQ_W-1:0] is the rise beat, [2*DQ_W-1:DQ_W] is the fall beat.
- wd_mask  in  2*DM_W  mask word, same rise/fall split as wd_data; 1 = byte masked.
- wd_valid  in  1  wd_data/wd_mask valid.
- wd_ready  out  1  serializer accepts a word on this edge.
- dq_rise, dq_fall  out  DQ_W each  ODDR D1/D2 for DQ.
- dm_rise, dm_fall  out  DM_W each  ODDR D1/D2 for DM.
- dq_oe  out  1  DQ/DM output enable.
- dqs_rise, dqs_fall  out  1 each  ODDR D1/D2 for DQS.
- dqs_oe  out  1  DQS output enable.
- err_underrun  out  1  sticky: wd_valid was low while wd_ready was high.
- err_overlap  out  1  sticky: wr_start arrived while busy.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Reset: when R is high at an edge, all outputs go to 0, the FSM goes to IDLE, counters go to 0 and both error flags clear. This applies mid-burst too: drivers turn off on the next cycle and no postamble is sent.
- FSM states: IDLE, WAIT, PRE, DATA, POST.
- IDLE:
  - wr_start=1 → WAIT, with wait_cnt = WL-2.
  - Call this acceptance edge t0.
- WAIT:
  - Lasts WL-1 cycles.
  - wait_cnt==0 → PRE; otherwise decrement.
- PRE (one cycle):
  - dqs_oe=1, dqs_rise=0, dqs_fall=0, dq_oe=0.
- DATA:
  - Lasts BURST_CYC cycles, tracked by beat_cnt counting 0..BURST_CYC-1.
  - dq_oe=1, dqs_oe=1, dqs_rise=1, dqs_fall=0.
  - After the last beat → POST.
- POST (one cycle):
  - dqs_oe=1, dqs_rise=0, dqs_fall=0, dq_oe=0 → IDLE.
- Latency: the first DATA cycle begins at edge t0+WL.
- wd_ready:
  - Registered.
  - High during PRE and during DATA cycles where beat_cnt < BURST_CYC-1.
  - Exactly BURST_CYC words are accepted per burst.
- Data capture:
  - Word capture at an edge with wd_ready=1 loads dq_*/dm_* from the word at that edge, and it becomes the next DATA beat.
  - If wd_valid=0 at such an edge: dq_rise/dq_fall=0, dm_rise/dm_fall all ones (the beat is masked), err_underrun is set, and the burst continues with unchanged timing.
- Outside DATA: dq_*/dm_* are 0.
- wr_start handling:
  - wr_start while busy is ignored and sets err_overlap.
  - wr_start in the POST cycle is also ignored; there are no back-to-back bursts.
- err_clr vs. set: if err_clr and a new error event occur on the same edge, set wins.
- Widths: wait_cnt is 4 bits; beat_cnt is 2 bits.

Optional Feature:
- Macro: DDR_WR_BURST_CNT_EN.
- Defined:
  - Adds output burst_cnt [15:0].
  - Increments on each POST→IDLE transition and saturates at 16'hFFFF.
  - Cleared by R; not cleared by err_clr.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
- WL=3, BURST_CYC=2, wd_valid always 1, words 0xA5A55A5A then 0x0F0FF0F0, pulse wr_start at t0:
  - wd_ready high at t0+2 and t0+3.
  - DATA at t0+3 and t0+4: dq_rise=0x5A5A, dq_fall=0xA5A5, then dq_rise=0xF0F0, dq_fall=0x0F0F.
  - dqs_oe high from t0+2 to t0+5; busy low after t0+5.
- BURST_CYC=4 with words 1..4: exactly 4 DATA cycles; dqs_rise/fall = 1/0 in each; wd_ready high for 4 cycles.
- Underrun: drop wd_valid for the second word → second beat has dq=0, dm_rise=dm_fall=2'b11; err_underrun=1 and stays 1 until err_clr.
- wr_start during WAIT, and again during POST → err_overlap=1, the first burst's timing is unchanged, and no second burst occurs.
- Assert R in the first DATA cycle → all outputs 0 and busy=0 on the next cycle; a new wr_start afterwards runs a clean burst.
- With DDR_WR_BURST_CNT_EN: run 3 bursts → burst_cnt=3; after R, burst_cnt=0.
